// File: rtl/adc_max10_pkg.sv
// Shared definitions for the MAX10 modular ADC stand-in and the controller that drives it.
// Covers channel numbering, response field widths and the conversion engine state encoding.
package adc_max10_pkg;

  localparam logic [4:0] ADC_CH_1    = 5'd1;
  localparam logic [4:0] ADC_CH_2    = 5'd2;
  localparam logic [4:0] ADC_CH_3    = 5'd3;
  localparam logic [4:0] ADC_CH_4    = 5'd4;
  localparam logic [4:0] ADC_CH_5    = 5'd5;
  localparam logic [4:0] ADC_CH_6    = 5'd6;
  localparam logic [4:0] ADC_CH_T    = 5'd17;
  localparam logic [4:0] ADC_CH_MAX  = 5'd17;
  localparam logic [4:0] ADC_CH_NONE = 5'd18;

  localparam int ADC_CH_W   = 5;
  localparam int ADC_DATA_W = 12;
  localparam int ADC_SCNT_W = ADC_DATA_W - ADC_CH_W;
  localparam int ADC_CMD_W  = ADC_CH_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } adc_eng_state_e;

  typedef struct packed {
    logic [ADC_CH_W-1:0] channel;
    logic                sop;
    logic                eop;
  } adc_cmd_t;

  // Channels past the temperature sensor read back as zero so the controller can spot them.
  function automatic logic [ADC_DATA_W-1:0] adc_sample_data(
    input logic [ADC_CH_W-1:0]   channel,
    input logic [ADC_SCNT_W-1:0] sample_cnt
  );
    if (channel <= ADC_CH_MAX) begin
      return {channel, sample_cnt};
    end
    return '0;
  endfunction

endpackage

// File: rtl/adc_cmd_fifo.sv
// Small synchronous command buffer in front of the ADC conversion engine.
// Push is dropped when full and pop is ignored when empty; DEPTH must be a power of two.
module adc_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic                       CLK,
  input  logic                       RESETn,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: entries are only ever read behind a valid count.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mfp_adc_max10_model.sv
// Synthesizable replacement for the MAX10 modular ADC hard IP on the command/response streams.
// Buffers commands, spends CONV_CYCLES per sample, returns one deterministic result per command.
//
//   state | meaning
//   IDLE  | nothing in flight, waiting for a buffered command
//   CONV  | converting the active entry, cnt counts down to 0
//   DONE  | response presented for one cycle, next entry popped if available
module mfp_adc_max10_model
  import adc_max10_pkg::*;
#(
  parameter int CONV_CYCLES = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  ADC_C_Valid,
  input  logic [ADC_CH_W-1:0]   ADC_C_Channel,
  input  logic                  ADC_C_SOP,
  input  logic                  ADC_C_EOP,
  output logic                  ADC_C_Ready,
  output logic                  ADC_R_Valid,
  output logic [ADC_CH_W-1:0]   ADC_R_Channel,
  output logic [ADC_DATA_W-1:0] ADC_R_Data,
  output logic                  ADC_R_SOP,
  output logic                  ADC_R_EOP,
  output logic                  Proto_Err
);

  localparam int         CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0] CNT_LOAD = 8'(CONV_CYCLES - 1);

  adc_eng_state_e        state_q;
  logic [7:0]            cnt_q;
  adc_cmd_t              act_q;
  logic [ADC_SCNT_W-1:0] scnt_q;
  logic                  r_valid_q;
  logic [ADC_CH_W-1:0]   r_ch_q;
  logic [ADC_DATA_W-1:0] r_data_q;
  logic                  r_sop_q;
  logic                  r_eop_q;
  logic                  in_pkt_q, in_pkt_d;
  logic                  err_q, err_d;

  adc_cmd_t              fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  cmd_push;
  logic                  eng_pop;

  // Ready depends only on the registered occupancy, never on Valid or on this cycle's pop.
  assign ADC_C_Ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign cmd_push    = ADC_C_Valid && !fifo_full;
  assign eng_pop     = ((state_q == IDLE) || (state_q == DONE)) && !fifo_empty;

  adc_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADC_CMD_W)
  ) u_cmd_fifo (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .push_i  (cmd_push),
    .data_i  ({ADC_C_Channel, ADC_C_SOP, ADC_C_EOP}),
    .pop_i   (eng_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      act_q     <= '{channel: ADC_CH_NONE, sop: 1'b0, eop: 1'b0};
      scnt_q    <= '0;
      r_valid_q <= 1'b0;
      r_ch_q    <= '0;
      r_data_q  <= '0;
      r_sop_q   <= 1'b0;
      r_eop_q   <= 1'b0;
    end else begin
      r_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            act_q   <= fifo_dout;
            cnt_q   <= CNT_LOAD;
            state_q <= CONV;
          end
        end
        CONV: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            state_q   <= DONE;
            r_valid_q <= 1'b1;
            r_ch_q    <= act_q.channel;
            r_data_q  <= adc_sample_data(act_q.channel, scnt_q);
            r_sop_q   <= act_q.sop;
            r_eop_q   <= act_q.eop;
          end
        end
        DONE: begin
          scnt_q <= scnt_q + ADC_SCNT_W'(1);
          if (!fifo_empty) begin
            act_q   <= fifo_dout;
            cnt_q   <= CNT_LOAD;
            state_q <= CONV;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // SOP must open a packet and anything else must continue one; SOP&EOP is a whole packet.
  always_comb begin
    in_pkt_d = in_pkt_q;
    err_d    = err_q;
    if (cmd_push) begin
      if (ADC_C_SOP == in_pkt_q) begin
        err_d = 1'b1;
      end
      in_pkt_d = !ADC_C_EOP && (ADC_C_SOP || in_pkt_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      in_pkt_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
      err_q    <= err_d;
    end
  end

  assign ADC_R_Valid   = r_valid_q;
  assign ADC_R_Channel = r_ch_q;
  assign ADC_R_Data    = r_data_q;
  assign ADC_R_SOP     = r_sop_q;
  assign ADC_R_EOP     = r_eop_q;
  assign Proto_Err     = err_q;

endmodule
